// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch unit: default widths, exit encoding,
// FSM state encoding and instruction field positions.
package fetch_unit_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int INSTR_WIDTH_DEF = 17;

    // An all-zero instruction word marks the end of a program.
    localparam logic [INSTR_WIDTH_DEF-1:0] EXIT_WORD = '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int OPCODE_MSB = 16;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 9;
    localparam int RS_MSB     = 8;
    localparam int RS_LSB     = 6;
    localparam int IMM_MSB    = 5;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/fetch_unit_pc.sv
// Program counter: clear to zero, load a redirect target, increment or hold.
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Increment wraps naturally at 2^ADDR_WIDTH.
    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program-memory address, registers the
// returned word for decode with a valid/ready handshake, and stops on exit.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; nothing fetched
// RUN     | fetching one word per cycle while decode keeps up
// HALT    | exit word seen; drain the held instruction, then stay quiet
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
    input  logic                   inClk,
    input  logic                   inRstN,
    input  logic                   inStart,
    output logic [ADDR_WIDTH-1:0]  outPmAddress,
    input  logic [INSTR_WIDTH-1:0] inPmData,
    input  logic                   inBranchValid,
    input  logic [ADDR_WIDTH-1:0]  inBranchTarget,
    output logic [INSTR_WIDTH-1:0] outInstr,
    output logic [ADDR_WIDTH-1:0]  outInstrPc,
    output logic                   outValid,
    input  logic                   inReady,
    output logic                   outHalted,
    output logic [15:0]            outFetchCount
);

    logic [1:0]             state_q,  state_d;
    logic [INSTR_WIDTH-1:0] instr_q,  instr_d;
    logic [ADDR_WIDTH-1:0]  ipc_q,    ipc_d;
    logic                   valid_q,  valid_d;
    logic                   halted_q, halted_d;
    logic [15:0]            count_q,  count_d;

    logic                   pc_clr;
    logic                   pc_load;
    logic                   pc_inc;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   transfer;
    logic                   load_slot;
    logic                   is_exit;

    fetch_pc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fetch_pc (
        .clk_i    (inClk),
        .rst_n_i  (inRstN),
        .clr_i    (pc_clr),
        .load_i   (pc_load),
        .target_i (inBranchTarget),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    assign transfer  = valid_q && inReady;
    assign load_slot = !valid_q || inReady;
    assign is_exit   = (inPmData == INSTR_WIDTH'(EXIT_WORD));

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        pc_clr   = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inStart) begin
                    state_d = ST_RUN;
                    pc_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                // Redirect beats load, stall and exit; the register is flushed.
                if (inBranchValid) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end else if (load_slot) begin
                    if (is_exit) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                    end else begin
                        instr_d = inPmData;
                        ipc_d   = pc;
                        valid_d = 1'b1;
                        pc_inc  = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (inStart) begin
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                    valid_d  = 1'b0;
                    pc_clr   = 1'b1;
                end else if (transfer) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign count_d = (transfer && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign outPmAddress  = pc;
    assign outInstr      = instr_q;
    assign outInstrPc    = ipc_q;
    assign outValid      = valid_q;
    assign outHalted     = halted_q;
    assign outFetchCount = count_q;

endmodule
